// File: rtl/play_game.sv
// Memory-match game core: 6x6 cursor, two-card select, reveal, match bookkeeping, LED compose.
// Latency: key/button edge acts at the sampling clock edge; LEDs are combinational from state registers.
// Backpressure: none; presses arriving while they cannot act (found card, SHOW, GAMEOVER) are dropped.
//
// Ports:
//   clock, resetN      rising-edge clock, asynchronous active-low reset
//   keys[3:0]          arrow keys {right, left, down, up}, active-high
//   A                  select button, active-high
//   LEDs[35:0]         one LED per grid position, index = row*6 + col

// LED composition and found-pair bookkeeping for the game core.
// Latency: LEDs combinational from registers; foundLocs/FP update on the edge set_found is high.
// Backpressure: none.
module play_game_led (
    input  logic        clock,
    input  logic        resetN,
    input  logic [5:0]  mem6x6,
    input  logic [5:0]  card1Loc,
    input  logic [5:0]  card2Loc,
    input  logic        card1_valid,
    input  logic        card2_valid,
    input  logic        set_found,
    input  logic        GO,
    output logic [35:0] LEDs,
    output logic [35:0] foundLocs,
    output logic        full_on_match,
    output logic        FP
);
    logic [35:0] memPosition;
    logic [35:0] card1LED;
    logic [35:0] card2LED;

    assign memPosition = 36'd1 << mem6x6;
    assign card1LED    = card1_valid ? (36'd1 << card1Loc) : 36'd0;
    assign card2LED    = card2_valid ? (36'd1 << card2Loc) : 36'd0;

    // True when marking the two shown cards would complete the board.
    assign full_on_match = &(foundLocs | card1LED | card2LED);

    assign LEDs = GO ? {36{1'b1}} : (memPosition | foundLocs | card1LED | card2LED);

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            foundLocs <= 36'd0;
            FP        <= 1'b0;
        end else begin
            FP <= set_found;
            if (set_found) begin
                foundLocs <= foundLocs | card1LED | card2LED;
            end
        end
    end
endmodule

// Game core top: cursor movement, card selection FSM, reveal timer, game-over detection.
// Latency: presses act at the edge they are first sampled high; match result SHOW_CYCLES edges after card2.
// Backpressure: none; held inputs act once, ignored presses are not queued.
module play_game #(
    parameter int SHOW_CYCLES = 8
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic [3:0]  keys,
    input  logic        A,
    output logic [35:0] LEDs
);
    localparam int CNT_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SHOW_CYCLES - 1);

    typedef enum logic [1:0] {
        SEL1     = 2'd0,
        SEL2     = 2'd1,
        SHOW     = 2'd2,
        GAMEOVER = 2'd3
    } state_t;

    state_t          state;
    logic [5:0]      mem6x6;
    logic [5:0]      card1Loc;
    logic [5:0]      card2Loc;
    logic [5:0]      selectedCard;
    logic [5:0]      card1_pair;
    logic            card1_valid;
    logic            card2_valid;
    logic            pair_match;
    logic            GO;
    logic [CNT_W-1:0] show_cnt;

    logic [3:0]      keys_prev;
    logic            a_prev;
    logic [3:0]      key_edge;
    logic            a_edge;
    logic [5:0]      col;
    logic [5:0]      next_pos;
    logic            found_here;
    logic            show_last;
    logic            set_found;
    logic [35:0]     foundLocs;
    logic            full_on_match;
    logic            fp_pulse;
    logic            unused_fp;

    // The match pulse is for observation only; nothing in the core consumes it.
    assign unused_fp = fp_pulse;

    assign key_edge     = keys & ~keys_prev;
    assign a_edge       = A & ~a_prev;
    assign col          = mem6x6 % 6'd6;
    // Positions p and p+18 share a pair ID.
    assign selectedCard = (mem6x6 >= 6'd18) ? (mem6x6 - 6'd18) : mem6x6;
    assign found_here   = foundLocs[mem6x6];
    assign show_last    = (state == SHOW) && (show_cnt == CNT_LAST);
    assign set_found    = show_last && pair_match;

    // Priority is decided by which edge arrived, not by whether the move is legal:
    // an up edge on the top row blocks a simultaneous down/left/right.
    always_comb begin
        next_pos = mem6x6;
        if (key_edge[0]) begin
            if (mem6x6 >= 6'd6) next_pos = mem6x6 - 6'd6;
        end else if (key_edge[1]) begin
            if (mem6x6 < 6'd30) next_pos = mem6x6 + 6'd6;
        end else if (key_edge[2]) begin
            if (col != 6'd0) next_pos = mem6x6 - 6'd1;
        end else if (key_edge[3]) begin
            if (col != 6'd5) next_pos = mem6x6 + 6'd1;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state       <= SEL1;
            mem6x6      <= 6'd0;
            card1Loc    <= 6'd0;
            card2Loc    <= 6'd0;
            card1_pair  <= 6'd0;
            card1_valid <= 1'b0;
            card2_valid <= 1'b0;
            pair_match  <= 1'b0;
            GO          <= 1'b0;
            show_cnt    <= '0;
            keys_prev   <= 4'd0;
            a_prev      <= 1'b0;
        end else begin
            keys_prev <= keys;
            a_prev    <= A;
            if (state != GAMEOVER) begin
                mem6x6 <= next_pos;
            end
            case (state)
                SEL1: begin
                    // Selection uses the pre-move cursor when A and an arrow coincide.
                    if (a_edge && !found_here) begin
                        card1Loc    <= mem6x6;
                        card1_pair  <= selectedCard;
                        card1_valid <= 1'b1;
                        state       <= SEL2;
                    end
                end
                SEL2: begin
                    if (a_edge && !found_here && (mem6x6 != card1Loc)) begin
                        card2Loc    <= mem6x6;
                        card2_valid <= 1'b1;
                        pair_match  <= (selectedCard == card1_pair);
                        show_cnt    <= '0;
                        state       <= SHOW;
                    end
                end
                SHOW: begin
                    if (show_last) begin
                        card1_valid <= 1'b0;
                        card2_valid <= 1'b0;
                        show_cnt    <= '0;
                        if (set_found && full_on_match) begin
                            GO    <= 1'b1;
                            state <= GAMEOVER;
                        end else begin
                            state <= SEL1;
                        end
                    end else begin
                        show_cnt <= show_cnt + 1'b1;
                    end
                end
                GAMEOVER: begin
                    GO <= 1'b1;
                end
                default: begin
                    state <= SEL1;
                end
            endcase
        end
    end

    play_game_led ledMod (
        .clock         (clock),
        .resetN        (resetN),
        .mem6x6        (mem6x6),
        .card1Loc      (card1Loc),
        .card2Loc      (card2Loc),
        .card1_valid   (card1_valid),
        .card2_valid   (card2_valid),
        .set_found     (set_found),
        .GO            (GO),
        .LEDs          (LEDs),
        .foundLocs     (foundLocs),
        .full_on_match (full_on_match),
        .FP            (fp_pulse)
    );
endmodule

// File: tb/tb_play_game.sv
// Directed bench for play_game: reset, mismatch, match, clamping, reselection, priority, full game.
module tb_play_game;
    localparam int SC = 8;

    logic        clock;
    logic        resetN;
    logic [3:0]  keys;
    logic        A;
    logic [35:0] LEDs;

    int checks   = 0;
    int failures = 0;
    int cur      = 0;

    play_game #(.SHOW_CYCLES(SC)) dut (
        .clock  (clock),
        .resetN (resetN),
        .keys   (keys),
        .A      (A),
        .LEDs   (LEDs)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive for one edge, then a low edge; returns at the negedge after the low edge.
    task automatic press(input logic [3:0] k, input logic a);
        keys = k;
        A    = a;
        @(posedge clock);
        @(negedge clock);
        keys = 4'd0;
        A    = 1'b0;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        resetN = 1'b0;
        @(negedge clock);
        resetN = 1'b1;
        cur    = 0;
    endtask

    // Walks the cursor from the bench-tracked position to tgt with single presses.
    task automatic goto_pos(input int tgt);
        int cr, cc, tr, tc;
        cr = cur / 6; cc = cur % 6; tr = tgt / 6; tc = tgt % 6;
        while (cr > tr) begin press(4'b0001, 1'b0); cr--; end
        while (cr < tr) begin press(4'b0010, 1'b0); cr++; end
        while (cc > tc) begin press(4'b0100, 1'b0); cc--; end
        while (cc < tc) begin press(4'b1000, 1'b0); cc++; end
        cur = tgt;
        check("goto", {30'd0, dut.mem6x6}, 36'(tgt));
    endtask

    initial begin
        resetN = 1'b0;
        keys   = 4'd0;
        A      = 1'b0;
        #1;
        check("rst_leds",  LEDs, 36'h1);
        check("rst_pos",   {30'd0, dut.mem6x6}, 36'd0);
        check("rst_go",    {35'd0, dut.GO}, 36'd0);
        check("rst_found", dut.ledMod.foundLocs, 36'd0);
        check("rst_fp",    {35'd0, dut.ledMod.FP}, 36'd0);
        @(negedge clock);
        resetN = 1'b1;

        // Mismatch: cards 1 and 5.
        press(4'b1000, 1'b0);
        press(4'b0000, 1'b1);
        repeat (4) press(4'b1000, 1'b0);
        press(4'b0000, 1'b1);
        check("mm_c1", {30'd0, dut.card1Loc}, 36'd1);
        check("mm_c2", {30'd0, dut.card2Loc}, 36'd5);
        check("mm_show_leds", LEDs, 36'h22);
        wait_cycles(SC - 2);
        check("mm_show_end_leds", LEDs, 36'h22);
        wait_cycles(1);
        check("mm_fp", {35'd0, dut.ledMod.FP}, 36'd0);
        check("mm_found", dut.ledMod.foundLocs, 36'd0);
        check("mm_leds", LEDs, 36'h20);

        // Match: cards 3 and 21.
        do_reset();
        repeat (3) press(4'b1000, 1'b0);
        press(4'b0000, 1'b1);
        repeat (3) press(4'b0010, 1'b0);
        press(4'b0000, 1'b1);
        check("m_c2", {30'd0, dut.card2Loc}, 36'd21);
        wait_cycles(SC - 2);
        check("m_fp_before", {35'd0, dut.ledMod.FP}, 36'd0);
        check("m_found_before", dut.ledMod.foundLocs, 36'd0);
        wait_cycles(1);
        check("m_fp_pulse", {35'd0, dut.ledMod.FP}, 36'd1);
        check("m_found", dut.ledMod.foundLocs, 36'h000200008);
        wait_cycles(1);
        check("m_fp_after", {35'd0, dut.ledMod.FP}, 36'd0);
        check("m_leds", LEDs, 36'h000200008);
        // A on a found position is ignored.
        press(4'b0000, 1'b1);
        check("m_found_sel", dut.ledMod.card1LED, 36'd0);

        // Clamping.
        do_reset();
        press(4'b0001, 1'b0);
        press(4'b0100, 1'b0);
        check("clamp_ul", {30'd0, dut.mem6x6}, 36'd0);
        repeat (7) press(4'b0010, 1'b0);
        check("clamp_down", {30'd0, dut.mem6x6}, 36'd30);
        repeat (7) press(4'b1000, 1'b0);
        check("clamp_right", {30'd0, dut.mem6x6}, 36'd35);

        // Reselecting card1 is ignored.
        do_reset();
        press(4'b1000, 1'b0);
        press(4'b0000, 1'b1);
        press(4'b0000, 1'b1);
        check("resel_c1led", dut.ledMod.card1LED, 36'h2);
        check("resel_c2led", dut.ledMod.card2LED, 36'd0);
        check("resel_leds", LEDs, 36'h2);

        // Priority and held keys.
        do_reset();
        press(4'b1000, 1'b0);
        press(4'b0010, 1'b0);
        check("prio_start", {30'd0, dut.mem6x6}, 36'd7);
        press(4'b1001, 1'b0);
        check("prio_up_right", {30'd0, dut.mem6x6}, 36'd1);
        keys = 4'b1000;
        wait_cycles(10);
        keys = 4'd0;
        wait_cycles(1);
        check("hold_right", {30'd0, dut.mem6x6}, 36'd2);
        // A and arrow on the same edge: select at the pre-move cursor.
        press(4'b1000, 1'b1);
        check("a_arrow_c1", {30'd0, dut.card1Loc}, 36'd2);
        check("a_arrow_pos", {30'd0, dut.mem6x6}, 36'd3);

        // Full game.
        do_reset();
        for (int p = 0; p < 18; p++) begin
            goto_pos(p);
            press(4'b0000, 1'b1);
            goto_pos(p + 18);
            press(4'b0000, 1'b1);
            if (p < 17) begin
                wait_cycles(SC - 1);
            end else begin
                wait_cycles(SC - 2);
                check("go_before", {35'd0, dut.GO}, 36'd0);
                wait_cycles(1);
            end
        end
        check("go", {35'd0, dut.GO}, 36'd1);
        check("go_found", dut.ledMod.foundLocs, 36'hFFFFFFFFF);
        check("go_leds", LEDs, 36'hFFFFFFFFF);
        press(4'b0001, 1'b0);
        press(4'b0100, 1'b1);
        check("go_frozen", {30'd0, dut.mem6x6}, 36'd35);
        check("go_leds_hold", LEDs, 36'hFFFFFFFFF);

        // Asynchronous reset out of GAMEOVER.
        @(negedge clock);
        #2;
        resetN = 1'b0;
        #1;
        check("ar_leds",  LEDs, 36'h1);
        check("ar_go",    {35'd0, dut.GO}, 36'd0);
        check("ar_found", dut.ledMod.foundLocs, 36'd0);
        check("ar_pos",   {30'd0, dut.mem6x6}, 36'd0);
        check("ar_fp",    {35'd0, dut.ledMod.FP}, 36'd0);
        @(negedge clock);
        resetN = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
